// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and register-file defaults.
package cpu_types_pkg;

    localparam int NREGS_DEF = 32;
    localparam int REG_AW    = $clog2(NREGS_DEF);

    typedef logic [31:0]       word_t;
    typedef logic [REG_AW-1:0] regbits_t;

    localparam regbits_t ZERO_IDX = '0;

endpackage

// File: rtl/rf_write_merge.sv
// Resolves NWR write ports into one winning write per register (highest port index wins),
// and flags any address claimed by more than one enabled port.
module rf_write_merge
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = $bits(word_t),
    parameter int NREGS    = NREGS_DEF,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    output logic [NREGS-1:0]      hit,
    output logic [DATA_W-1:0]     merged [NREGS],
    output logic                  collide
);

    // NOTE: blocking assignments in always_comb; every output gets a default first so no
    // latch is inferred and later (higher-index) ports overwrite earlier ones in order.
    always_comb begin
        hit     = '0;
        collide = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            merged[r] = '0;
        end
        for (int i = 0; i < NWR; i++) begin
            automatic logic [AW-1:0] a = wsel[i*AW +: AW];
            if (wen[i] && !((ZERO_REG != 0) && (a == AW'(ZERO_IDX)))) begin
                if (hit[a]) begin
                    collide = 1'b1;
                end
                hit[a]    = 1'b1;
                merged[a] = wdat[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port GPR file with write-to-read bypass, a per-register busy scoreboard
// for RAW hazard detection, and a registered write-collision flag.
module register_file_mp
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = $bits(word_t),
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rbusy,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_sel,
    output logic [NREGS-1:0]      busy,
    output logic                  wcollide
);

    logic [DATA_W-1:0] regs   [NREGS];
    logic [DATA_W-1:0] merged [NREGS];
    logic [NREGS-1:0]  hit;
    logic              collide;
    logic [NREGS-1:0]  busy_nxt;

    rf_write_merge #(
        .DATA_W   (DATA_W),
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_merge (
        .wen     (wen),
        .wsel    (wsel),
        .wdat    (wdat),
        .hit     (hit),
        .merged  (merged),
        .collide (collide)
    );

    // NOTE: the storage array is reset explicitly because reset must clear every register;
    // this makes it flops rather than an SRAM macro, which is intended for a GPR file.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (hit[r]) begin
                    regs[r] <= merged[r];
                end
            end
        end
    end

    // Writeback clears first, then a reserve re-marks its register: the new producer is outstanding.
    always_comb begin
        busy_nxt = busy & ~hit;
        if (rsv_en && !((ZERO_REG != 0) && (rsv_sel == AW'(ZERO_IDX)))) begin
            busy_nxt[rsv_sel] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            busy     <= '0;
            wcollide <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            wcollide <= collide;
        end
    end

    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            automatic logic [AW-1:0]     a = rsel[j*AW +: AW];
            automatic logic [DATA_W-1:0] d = regs[a];
            automatic logic              b = busy[a];
            if ((BYPASS != 0) && hit[a]) begin
                d = merged[a];
                b = 1'b0;
            end
            if ((ZERO_REG != 0) && (a == AW'(ZERO_IDX))) begin
                d = '0;
            end
            rdat[j*DATA_W +: DATA_W] = d;
            rbusy[j]                 = b;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_register_file_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AWB = 5;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [1:0]      wen;
    logic [2*AWB-1:0] wsel;
    logic [2*DW-1:0] wdat;
    logic [2*AWB-1:0] rsel;
    logic            rsv_en;
    logic [AWB-1:0]  rsv_sel;

    logic [2*DW-1:0] rdat,  rdat_nb;
    logic [1:0]      rbusy, rbusy_nb;
    logic [NR-1:0]   busy,  busy_nb;
    logic            wcollide, wcollide_nb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    register_file_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
        .rdat(rdat), .rbusy(rbusy), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .busy(busy), .wcollide(wcollide)
    );

    register_file_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
        .rdat(rdat_nb), .rbusy(rbusy_nb), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .busy(busy_nb), .wcollide(wcollide_nb)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wen    = '0;
        wsel   = '0;
        wdat   = '0;
        rsv_en = 1'b0;
        rsv_sel = '0;
    endtask

    task automatic set_wr(input int p, input logic [AWB-1:0] a, input logic [DW-1:0] d);
        wen[p]           = 1'b1;
        wsel[p*AWB +: AWB] = a;
        wdat[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AWB-1:0] a);
        rsel[p*AWB +: AWB] = a;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rdat[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rd_nb(input int p);
        return rdat_nb[p*DW +: DW];
    endfunction

    task automatic test_reset();
        logic [DW-1:0] v;
        idle();
        rsel = '0;
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        for (int r = 0; r < NR; r += 2) begin
            set_wr(0, AWB'(r), 32'h1000_0000 + r);
            set_wr(1, AWB'(r + 1), 32'h1000_0000 + r + 1);
            tick();
        end
        idle();
        rsv_en = 1'b1; rsv_sel = 5'd17;
        tick();
        idle();
        set_rd(0, 5'd17);
        #1;
        n_cmp++;
        if (rd(0) !== 32'h1000_0011) begin
            n_err++; $display("FAIL pre_reset_reg17 got %h want %h", rd(0), 32'h1000_0011);
        end
        n_cmp++;
        if (busy !== 32'h0002_0000) begin
            n_err++; $display("FAIL pre_reset_busy got %h want %h", busy, 32'h0002_0000);
        end
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        for (int r = 0; r < NR; r++) begin
            set_rd(0, AWB'(r));
            set_rd(1, AWB'(r));
            #1;
            v = rd(0);
            n_cmp++;
            if (v !== '0 || rd(1) !== '0) begin
                n_err++; $display("FAIL reset_reg%0d got %h/%h want 0", r, v, rd(1));
            end
        end
        n_cmp++;
        if (busy !== '0 || wcollide !== 1'b0 || rbusy !== 2'b00) begin
            n_err++; $display("FAIL reset_busy got busy=%h wcol=%b rbusy=%b want 0", busy, wcollide, rbusy);
        end
    endtask

    task automatic test_write();
        idle();
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        set_rd(0, 5'd5);
        #1;
        n_cmp++;
        if (rd(0) !== 32'hDEAD_BEEF || rd_nb(0) !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL write_reg5 got %h/%h want deadbeef", rd(0), rd_nb(0));
        end
        set_wr(1, 5'd0, 32'h0000_1234);
        set_rd(1, 5'd0);
        #1;
        n_cmp++;
        if (rd(1) !== '0) begin
            n_err++; $display("FAIL zero_bypass got %h want 0", rd(1));
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd(1) !== '0 || rd_nb(1) !== '0) begin
            n_err++; $display("FAIL write_reg0 got %h/%h want 0", rd(1), rd_nb(1));
        end
    endtask

    task automatic test_bypass();
        idle();
        set_wr(0, 5'd7, 32'h0BAD_F00D);
        tick();
        idle();
        set_wr(0, 5'd7, 32'hA5A5_A5A5);
        set_rd(1, 5'd7);
        #1;
        n_cmp++;
        if (rd(1) !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL bypass_on got %h want a5a5a5a5", rd(1));
        end
        n_cmp++;
        if (rd_nb(1) !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL bypass_off got %h want 0badf00d", rd_nb(1));
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd(1) !== 32'hA5A5_A5A5 || rd_nb(1) !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL bypass_stored got %h/%h want a5a5a5a5", rd(1), rd_nb(1));
        end
    endtask

    task automatic test_collision();
        idle();
        set_wr(0, 5'd9, 32'h11);
        set_wr(1, 5'd9, 32'h22);
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        n_cmp++;
        if (rd(0) !== 32'h22) begin
            n_err++; $display("FAIL collide_winner got %h want 22", rd(0));
        end
        n_cmp++;
        if (wcollide !== 1'b1 || wcollide_nb !== 1'b1) begin
            n_err++; $display("FAIL collide_flag got %b/%b want 1", wcollide, wcollide_nb);
        end
        tick();
        n_cmp++;
        if (wcollide !== 1'b0) begin
            n_err++; $display("FAIL collide_pulse got %b want 0", wcollide);
        end
        set_wr(0, 5'd10, 32'h33);
        set_wr(1, 5'd11, 32'h44);
        tick();
        n_cmp++;
        if (wcollide !== 1'b0) begin
            n_err++; $display("FAIL collide_distinct got %b want 0", wcollide);
        end
        idle();
        set_wr(0, 5'd0, 32'h11);
        set_wr(1, 5'd0, 32'h22);
        tick();
        idle();
        n_cmp++;
        if (wcollide !== 1'b0) begin
            n_err++; $display("FAIL collide_reg0 got %b want 0", wcollide);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1'b1; rsv_sel = 5'd3;
        tick();
        idle();
        set_rd(0, 5'd3);
        #1;
        n_cmp++;
        if (busy[3] !== 1'b1 || rbusy[0] !== 1'b1) begin
            n_err++; $display("FAIL reserve got busy=%b rbusy=%b want 1", busy[3], rbusy[0]);
        end
        set_wr(1, 5'd3, 32'h300);
        #1;
        n_cmp++;
        if (rbusy[0] !== 1'b0 || rbusy_nb[0] !== 1'b1) begin
            n_err++; $display("FAIL rbusy_clear got %b/%b want 0/1", rbusy[0], rbusy_nb[0]);
        end
        tick();
        idle();
        n_cmp++;
        if (busy[3] !== 1'b0) begin
            n_err++; $display("FAIL writeback_clear got %b want 0", busy[3]);
        end
        set_wr(0, 5'd3, 32'h333);
        rsv_en = 1'b1; rsv_sel = 5'd3;
        tick();
        idle();
        #1;
        n_cmp++;
        if (busy[3] !== 1'b1 || rd(0) !== 32'h333) begin
            n_err++; $display("FAIL reserve_wins got busy=%b reg3=%h want 1/333", busy[3], rd(0));
        end
        rsv_en = 1'b1; rsv_sel = 5'd3;
        tick();
        idle();
        n_cmp++;
        if (busy !== 32'h0000_0008) begin
            n_err++; $display("FAIL reserve_busy got %h want 00000008", busy);
        end
    endtask

    task automatic test_zero_and_reset();
        idle();
        rsv_en = 1'b1; rsv_sel = 5'd0;
        tick();
        idle();
        n_cmp++;
        if (busy[0] !== 1'b0 || busy_nb[0] !== 1'b0) begin
            n_err++; $display("FAIL reserve_reg0 got %b/%b want 0", busy[0], busy_nb[0]);
        end
        set_wr(0, 5'd20, 32'hCAFE);
        set_wr(1, 5'd20, 32'hF00D);
        rsv_en = 1'b1; rsv_sel = 5'd21;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        idle();
        set_rd(0, 5'd20);
        set_rd(1, 5'd5);
        #1;
        n_cmp++;
        if (busy !== '0 || busy_nb !== '0 || wcollide !== 1'b0) begin
            n_err++; $display("FAIL reset_override_state got busy=%h wcol=%b want 0", busy, wcollide);
        end
        n_cmp++;
        if (rd(0) !== '0 || rd(1) !== '0) begin
            n_err++; $display("FAIL reset_override_regs got %h/%h want 0", rd(0), rd(1));
        end
    endtask

    initial begin
        nRST = 1'b0;
        rsel = '0;
        idle();
        test_reset();
        test_write();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_zero_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
